// File: rtl/sccb_init_sequencer.sv
// Walks a (register, value) table ROM and drives the SCCB controller handshake:
// START, WRITE id, WRITE reg, WRITE value, STOP per entry, plus delay and end-marker entries.
module sccb_init_sequencer #(
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter int unsigned TBL_AW      = 8,
  parameter int unsigned DELAY_TICKS = 24000,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              sccb_flag,
  output logic [3:0]        sccb_cmd,
  output logic [7:0]        sccb_dat,
  input  logic              sccb_busy,
  output logic              active,
  output logic              done,
  output logic              err,
  output logic [TBL_AW:0]   reg_cnt
);

  localparam int unsigned DlyW = 8 + $clog2(DELAY_TICKS + 1);
  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned MaxW = (AckW > GapW) ? AckW : GapW;
  localparam int unsigned CntW = (DlyW > MaxW) ? DlyW : MaxW;

  localparam logic [3:0] CmdStart = 4'b0001;
  localparam logic [3:0] CmdWrite = 4'b0010;
  localparam logic [3:0] CmdStop  = 4'b0110;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWaitAck,
    StWaitDone,
    StGap,
    StDelay,
    StNext,
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic              start_q;
  logic [TBL_AW-1:0] addr_q, addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        phase_q, phase_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        val_q, val_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [7:0]        dat_q, dat_d;
  logic              active_q, active_d;
  logic              err_q, err_d;
  logic [TBL_AW:0]   reg_cnt_q, reg_cnt_d;
  logic              start_rise;

  // {cmd, dat} for each phase of a register write transaction.
  function automatic logic [11:0] phase_word(input logic [2:0] ph, input logic [7:0] r,
                                             input logic [7:0] v);
    logic [11:0] w;
    case (ph)
      3'd0:    w = {CmdStart, 8'h00};
      3'd1:    w = {CmdWrite, DEV_ID};
      3'd2:    w = {CmdWrite, r};
      3'd3:    w = {CmdWrite, v};
      default: w = {CmdStop, 8'h00};
    endcase
    return w;
  endfunction

  assign start_rise = start & ~start_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    reg_d     = reg_q;
    val_d     = val_q;
    cmd_d     = cmd_q;
    dat_d     = dat_q;
    active_d  = active_q;
    err_d     = err_q;
    reg_cnt_d = reg_cnt_q;

    case (state_q)
      StIdle: begin
        if (start_rise && !active_q) begin
          addr_d    = '0;
          reg_cnt_d = '0;
          err_d     = 1'b0;
          active_d  = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        reg_d = tbl_data[15:8];
        val_d = tbl_data[7:0];
        if (tbl_data == 16'hFFFF) begin
          state_d = StDone;
        end else if (tbl_data[15:8] == 8'hFE) begin
          if (tbl_data[7:0] == 8'h00) begin
            state_d = StNext;
          end else begin
            cnt_d   = CntW'(DlyW'(tbl_data[7:0]) * DlyW'(DELAY_TICKS));
            state_d = StDelay;
          end
        end else begin
          phase_d        = 3'd0;
          {cmd_d, dat_d} = phase_word(3'd0, tbl_data[15:8], tbl_data[7:0]);
          state_d        = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (sccb_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
          // err rises on entry to StErr so it lands ACK_TIMEOUT cycles after the wait began.
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (!sccb_busy) begin
          if (phase_q != 3'd4) begin
            phase_d        = phase_q + 3'd1;
            {cmd_d, dat_d} = phase_word(phase_q + 3'd1, reg_q, val_q);
            state_d        = StIssue;
          end else begin
            reg_cnt_d = reg_cnt_q + (TBL_AW + 1)'(1);
            cnt_d     = '0;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          state_d = StNext;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDelay: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StNext;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StNext: begin
        // The last address has been consumed; stop rather than wrap.
        if (&addr_q) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + TBL_AW'(1);
          state_d = StFetch;
        end
      end
      StDone: begin
        active_d = 1'b0;
        state_d  = StIdle;
      end
      StErr: begin
        active_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      phase_q   <= 3'd0;
      reg_q     <= 8'h00;
      val_q     <= 8'h00;
      cmd_q     <= 4'h0;
      dat_q     <= 8'h00;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
      reg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      reg_q     <= reg_d;
      val_q     <= val_d;
      cmd_q     <= cmd_d;
      dat_q     <= dat_d;
      active_q  <= active_d;
      err_q     <= err_d;
      reg_cnt_q <= reg_cnt_d;
    end
  end

  // Strobe and done decode straight from state so reset drops them asynchronously.
  assign sccb_flag = (state_q == StIssue);
  assign done      = (state_q == StDone);
  assign tbl_addr  = addr_q;
  assign sccb_cmd  = cmd_q;
  assign sccb_dat  = dat_q;
  assign active    = active_q;
  assign err       = err_q;
  assign reg_cnt   = reg_cnt_q;

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
Sequences the SCCB controller to write a camera register table after power-up or on request. It fetches (register, value) pairs from an external synchronous table ROM and expands each pair into the SCCB command sequence START, WRITE id, WRITE reg, WRITE value, STOP. It issues each command through the controller's flag/cmd/dat/busy handshake. It also supports delay entries, an end marker, and a busy-acknowledge timeout.

Parameters:
DEV_ID, 8'h42, SCCB write device ID, sent as the first WRITE of each transaction.
TBL_AW, 8, table address width.
DELAY_TICKS, 24000, sys_clk cycles per delay unit.
ACK_TIMEOUT, 15, maximum cycles to wait for busy=1 after a flag pulse.
GAP_CYCLES, 4, idle cycles after each STOP before the next fetch.

Ports:
sys_clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
start  in  1  level; a rising edge while not active begins a run.
tbl_addr  out  TBL_AW  table ROM address.
tbl_data  in  16  ROM data {reg[15:8], value[7:0]}, valid 1 cycle after tbl_addr.
sccb_flag  out  1  command strobe to the controller (in_flag).
sccb_cmd  out  4  command: START=4'b0001, WRITE=4'b0010, STOP=4'b0110.
sccb_dat  out  8  write data to the controller (in_dat).
sccb_busy  in  1  controller busy.
active  out  1  run in progress.
done  out  1  one-cycle pulse at the end of a successful run.
err  out  1  sticky timeout error; cleared only by the next accepted start.
reg_cnt  out  TBL_AW+1  register writes completed in the current run.

Behaviour:
- Clock and reset: single clock sys_clk; reset rst is asynchronous and active-low.
- Reset values: tbl_addr=0, sccb_flag=0, sccb_cmd=0, sccb_dat=0, active=0, done=0, err=0, reg_cnt=0, state=IDLE.
- Start detection: start rising edge is detected with a registered copy of start.
  - Ignored while active=1.
  - Accepted: tbl_addr<=0, reg_cnt<=0, err<=0, active<=1, go to FETCH.
- FETCH: one cycle for ROM latency. Then DECODE samples tbl_data.
- DECODE:
  - 16'hFFFF: end marker, go to DONE.
  - reg==8'hFE: delay entry. Load a counter with value*DELAY_TICKS (product width wide enough, no overflow), go to DELAY. If value==0, go directly to NEXT.
  - Otherwise: set phase=0 and go to ISSUE.
- Phase mapping (cmd/dat per phase):
  - 0: START / 0.
  - 1: WRITE / DEV_ID.
  - 2: WRITE / reg.
  - 3: WRITE / value.
  - 4: STOP / 0.
- ISSUE: sccb_flag=1 for exactly one cycle. sccb_cmd and sccb_dat are valid in that cycle and are held stable until WAIT_DONE exits.
- WAIT_ACK: sccb_flag=0.
  - sccb_busy=1 → WAIT_DONE.
  - ACK_TIMEOUT cycles elapse without busy → ERR.
- WAIT_DONE: wait for sccb_busy=0, with no timeout.
  - If phase<4: phase+1, back to ISSUE. This guarantees sccb_flag is low for at least 2 cycles between strobes.
  - If phase==4: reg_cnt+1, go to GAP.
- GAP: wait GAP_CYCLES cycles, then NEXT.
- DELAY: decrement the counter to 0, then NEXT.
- NEXT:
  - tbl_addr==all-ones: go to DONE. No wrap; the last entry has already been processed.
  - Otherwise: tbl_addr+1, go to FETCH.
- DONE: done=1 for one cycle, active<=0, go to IDLE. tbl_addr and reg_cnt hold their values.
- ERR: err<=1, active<=0, sccb_flag=0, go to IDLE. No STOP is issued. tbl_addr holds the failing entry.
- Simultaneous events: start edge in the same cycle as DONE/ERR is ignored (active is still 1).
- Reset mid-operation: every register returns to its reset value immediately, and sccb_flag drops asynchronously. A subsequent start restarts at address 0.
- Never issues READ (4'b0011). Never asserts sccb_flag outside ISSUE.

Test Plan:
- Table {16'h1280, 16'hFFFF}, controller model → exactly 5 strobes with (cmd,dat) = (1,00), (2,42), (2,12), (2,80), (6,00); then done pulse; reg_cnt=1; err=0.
- Table {16'h1101, 16'hFE03, 16'h1202, 16'hFFFF}, DELAY_TICKS=10 → 30 cycles of DELAY plus GAP between first STOP completion and second START strobe; reg_cnt=2.
- sccb_busy tied 0, ACK_TIMEOUT=15 → one strobe only; err=1 exactly 15 cycles after WAIT_ACK entry; active=0; done never pulses; tbl_addr=0.
- Reset asserted during phase 2 WAIT_DONE → all outputs 0 in the same cycle; after release, start → sequence restarts at tbl_addr=0 with a START strobe.
- Second start edge during an active run → ignored, strobe count unchanged. Start after an err run → err cleared on acceptance.
- TBL_AW=2, 4 normal entries, no end marker → 20 strobes; done after entry 3; reg_cnt=4; tbl_addr=3.
